// File: rtl/ysyx_23060208_lsu_axi_master_if.sv
// Five-channel AXI-lite-style bus between the LSU and the data SRAM.
// The master modport is the LSU side; the slave modport is the SRAM side.
interface ysyx_23060208_lsu_axi_master_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [2:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [DATA_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ysyx_23060208_lsu_axi_master.sv
// LSU bus initiator: runs one load or store at a time on the data-SRAM bus.
// Optional LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses without a bus transaction.
module ysyx_23060208_lsu_axi_master #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  resp_is_store,
    ysyx_23060208_lsu_axi_master_if.master dsram
);

    localparam int unsigned PAD_B = DATA_WIDTH - 8;
    localparam int unsigned PAD_H = DATA_WIDTH - 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B,
        S_RESP
    } state_t;

    state_t     state;
    logic [1:0] size_q;
    logic       unsigned_q;

    // Load data arrives with the addressed byte in the low lane.
    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [DATA_WIDTH-1:0] d,
        input logic [1:0]            sz,
        input logic                  uns
    );
        logic [DATA_WIDTH-1:0] r;
        r = d;
        case (sz)
            2'd0:    r = uns ? {{PAD_B{1'b0}}, d[7:0]}  : {{PAD_B{d[7]}}, d[7:0]};
            2'd1:    r = uns ? {{PAD_H{1'b0}}, d[15:0]} : {{PAD_H{d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Size 3 falls into the word encoding.
    function automatic logic [2:0] size_to_strb(input logic [1:0] sz);
        logic [2:0] s;
        case (sz)
            2'd0:    s = 3'd1;
            2'd1:    s = 3'd2;
            default: s = 3'd4;
        endcase
        return s;
    endfunction

`ifdef LSU_MISALIGN_CHECK_EN
    logic misaligned_c;
    assign misaligned_c = ((req_size == 2'd1) && req_addr[0]) ||
                          (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            resp_is_store  <= 1'b0;
            size_q         <= 2'd0;
            unsigned_q     <= 1'b0;
            dsram.awaddr   <= '0;
            dsram.awvalid  <= 1'b0;
            dsram.wdata    <= '0;
            dsram.wstrb    <= 3'd0;
            dsram.wvalid   <= 1'b0;
            dsram.bready   <= 1'b0;
            dsram.araddr   <= '0;
            dsram.arvalid  <= 1'b0;
            dsram.rready   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
`ifdef LSU_MISALIGN_CHECK_EN
                        if (misaligned_c) begin
                            resp_valid    <= 1'b1;
                            resp_err      <= 1'b1;
                            resp_rdata    <= '0;
                            resp_is_store <= req_wen;
                            state         <= S_RESP;
                        end else
`endif
                        if (req_wen) begin
                            dsram.awaddr  <= req_addr;
                            dsram.wdata   <= req_wdata;
                            dsram.wstrb   <= size_to_strb(req_size);
                            dsram.awvalid <= 1'b1;
                            state         <= S_AW;
                        end else begin
                            dsram.araddr  <= req_addr;
                            dsram.arvalid <= 1'b1;
                            state         <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (dsram.arready) begin
                        dsram.arvalid <= 1'b0;
                        dsram.rready  <= 1'b1;
                        state         <= S_R;
                    end
                end
                S_R: begin
                    if (dsram.rvalid) begin
                        dsram.rready  <= 1'b0;
                        resp_rdata    <= extend_load(dsram.rdata, size_q, unsigned_q);
                        resp_err      <= (dsram.rresp != 2'b00);
                        resp_is_store <= 1'b0;
                        resp_valid    <= 1'b1;
                        state         <= S_RESP;
                    end
                end
                S_AW: begin
                    // W is held back until the address has been taken.
                    if (dsram.awready) begin
                        dsram.awvalid <= 1'b0;
                        dsram.wvalid  <= 1'b1;
                        state         <= S_W;
                    end
                end
                S_W: begin
                    if (dsram.wready) begin
                        dsram.wvalid <= 1'b0;
                        dsram.bready <= 1'b1;
                        state        <= S_B;
                    end
                end
                S_B: begin
                    if (dsram.bvalid) begin
                        dsram.bready  <= 1'b0;
                        resp_rdata    <= '0;
                        resp_err      <= (dsram.bresp != 2'b00);
                        resp_is_store <= 1'b1;
                        resp_valid    <= 1'b1;
                        state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
